// File: rtl/scroll_if.sv
// Scroll controller bus: vsync/control requests in, draw offsets out.
// master = timing/control side, slave = scroll_ctrl.
interface scroll_if;
    logic        vsync_in;
    logic        start;
    logic        brake;
    logic        steer_left;
    logic        steer_right;
    logic [10:0] xpos;
    logic [10:0] ypos;
    logic [3:0]  speed;
    logic [1:0]  state;
    logic        frame_tick;

    modport master (
        output vsync_in, start, brake, steer_left, steer_right,
        input  xpos, ypos, speed, state, frame_tick
    );

    modport slave (
        input  vsync_in, start, brake, steer_left, steer_right,
        output xpos, ypos, speed, state, frame_tick
    );
endinterface

// File: rtl/scroll_ctrl.sv
// Frame-synchronous scroll FSM (idle/accel/cruise/brake) driving draw_img xpos/ypos.
// Latency: 2 pclk from vsync rising edge to updated outputs; no backpressure, inputs are levels.
module scroll_ctrl #(
    parameter int TILE_H       = 128,
    parameter int X_MAX        = 896,
    parameter int X_INIT       = 448,
    parameter int MAX_SPEED    = 8,
    parameter int ACCEL_FRAMES = 4
) (
    input  logic     pclk,
    input  logic     rst,
    scroll_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCEL  = 2'd1,
        CRUISE = 2'd2,
        BRAKE  = 2'd3
    } state_t;

    localparam logic [10:0] XI    = 11'(X_INIT);
    localparam logic [10:0] XM    = 11'(X_MAX);
    localparam logic [11:0] TH    = 12'(TILE_H);
    localparam logic [3:0]  MS    = 4'(MAX_SPEED);
    localparam logic [7:0]  ACC_F = 8'(ACCEL_FRAMES);

    state_t      state_q, state_d;
    logic [10:0] xpos_q, xpos_d;
    logic [10:0] ypos_q, ypos_d;
    logic [3:0]  speed_q, speed_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        latch_q, latch_d;
    logic        vsync_q, vsync_d;
    logic        armed_q, armed_d;
    logic        frame_tick_q, frame_tick_d;
    logic [11:0] ysum;
    logic [3:0]  spd_new;

    always_comb begin
        state_d  = state_q;
        xpos_d   = xpos_q;
        ypos_d   = ypos_q;
        speed_d  = speed_q;
        cnt_d    = cnt_q;
        latch_d  = latch_q;
        spd_new  = speed_q;
        ysum     = {1'b0, ypos_q} + {8'd0, speed_q};
        vsync_d  = bus.vsync_in;
        // After reset a low vsync must be seen first, so a held-high vsync cannot fake an edge.
        armed_d  = armed_q | ~bus.vsync_in;
        frame_tick_d = bus.vsync_in & ~vsync_q & armed_q;

        if (state_q == IDLE && bus.start)
            latch_d = 1'b1;

        if (frame_tick_q) begin
            ypos_d = (ysum >= TH) ? 11'(ysum - TH) : ysum[10:0];

            if (state_q != IDLE) begin
                if (bus.steer_left && !bus.steer_right)
                    xpos_d = (xpos_q == 11'd0) ? 11'd0 : xpos_q - 11'd1;
                else if (bus.steer_right && !bus.steer_left)
                    xpos_d = (xpos_q >= XM) ? XM : xpos_q + 11'd1;
            end

            case (state_q)
                IDLE: begin
                    xpos_d = XI;
                    if (latch_q) begin
                        state_d = ACCEL;
                        speed_d = 4'd0;
                        cnt_d   = 8'd0;
                        latch_d = 1'b0;
                    end
                end
                ACCEL: begin
                    if (bus.brake) begin
                        state_d = BRAKE;
                        cnt_d   = 8'd0;
                    end else begin
                        if (cnt_q + 8'd1 == ACC_F) begin
                            cnt_d   = 8'd0;
                            spd_new = speed_q + 4'd1;
                        end else begin
                            cnt_d   = cnt_q + 8'd1;
                        end
                        speed_d = spd_new;
                        if (spd_new == MS)
                            state_d = CRUISE;
                    end
                end
                CRUISE: begin
                    if (bus.brake)
                        state_d = BRAKE;
                end
                BRAKE: begin
                    spd_new = (speed_q == 4'd0) ? 4'd0 : speed_q - 4'd1;
                    speed_d = spd_new;
                    if (spd_new == 4'd0) begin
                        state_d = IDLE;
                        xpos_d  = XI;
                    end else if (!bus.brake) begin
                        state_d = ACCEL;
                        cnt_d   = 8'd0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            xpos_q       <= XI;
            ypos_q       <= 11'd0;
            speed_q      <= 4'd0;
            cnt_q        <= 8'd0;
            latch_q      <= 1'b0;
            vsync_q      <= 1'b0;
            armed_q      <= 1'b0;
            frame_tick_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            xpos_q       <= xpos_d;
            ypos_q       <= ypos_d;
            speed_q      <= speed_d;
            cnt_q        <= cnt_d;
            latch_q      <= latch_d;
            vsync_q      <= vsync_d;
            armed_q      <= armed_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign bus.xpos       = xpos_q;
    assign bus.ypos       = ypos_q;
    assign bus.speed      = speed_q;
    assign bus.state      = state_q;
    assign bus.frame_tick = frame_tick_q;

endmodule

// File: doc/scroll_ctrl.md
Name: scroll_ctrl

Overview:
- Frame-synchronous scroll/motion controller that produces the xpos/ypos offsets consumed by the background draw_img stage.
- It sequences the road scroll through four states: idle, accelerate, cruise and brake. It updates offsets once per frame, triggered by the rising edge of vsync, so the image never tears mid-frame.
- It sits in the 65 MHz pixel domain between the xga_timing outputs and draw_img.

Parameters:
- TILE_H, 128, vertical tile period; ypos wraps modulo TILE_H.
- X_MAX, 896, maximum xpos (screen width minus tile width).
- X_INIT, 448, xpos value at reset and on return to IDLE.
- MAX_SPEED, 8, top speed in pixels/frame (1..15).
- ACCEL_FRAMES, 4, frames per +1 speed step in ACCEL.

Ports:
- pclk  in  1  pixel clock, 65 MHz.
- rst  in  1  asynchronous, active-low reset.
- vsync_in  in  1  vsync from xga_timing, synchronous to pclk.
- start  in  1  request to begin racing; level, sampled every cycle.
- brake  in  1  brake request; level.
- steer_left  in  1  move left request; level.
- steer_right  in  1  move right request; level.
- xpos  out  11  horizontal offset to draw_img, registered.
- ypos  out  11  vertical scroll offset to draw_img, registered, always < TILE_H.
- speed  out  4  current speed in pixels/frame, registered.
- state  out  2  current state: IDLE=0, ACCEL=1, CRUISE=2, BRAKE=3.
- frame_tick  out  1  one-cycle pulse, one cycle after each vsync rising edge.

Behaviour:
- Reset values: xpos=X_INIT, ypos=0, speed=0, state=IDLE, frame_tick=0, accel frame counter=0, start latch=0, vsync delay flop=0.
- Frame tick generation:
  - vsync_in is registered once.
  - A rising edge (registered=0, current=1) sets frame_tick=1 in the next cycle.
  - All offset, speed and state updates occur only in the cycle where frame_tick=1.
  - If vsync is held high, only one tick is produced.
- Start latch: start=1 in any cycle while state=IDLE sets the latch. The latch clears when the ACCEL transition is taken.
- Steering, evaluated at each tick in every state except IDLE:
  - steer_left only: xpos -= 1, saturating at 0.
  - steer_right only: xpos += 1, saturating at X_MAX.
  - Both or neither: xpos holds.
- Scroll at each tick: ypos = (ypos + speed) mod TILE_H. This uses the speed value held before this tick's speed update, with a single conditional subtract (speed < TILE_H is guaranteed).
- State machine, evaluated only at a tick:
  - IDLE: if the start latch is set, go to ACCEL with speed=0 and counter=0. Otherwise stay; xpos is forced to X_INIT.
  - ACCEL:
    - If brake=1, go to BRAKE; counter cleared.
    - Otherwise counter += 1. When counter reaches ACCEL_FRAMES, counter=0 and speed += 1.
    - If the new speed equals MAX_SPEED, go to CRUISE.
  - CRUISE: if brake=1, go to BRAKE; otherwise stay with speed constant.
  - BRAKE:
    - speed -= 1 per tick, floored at 0.
    - If the new speed is 0, go to IDLE with xpos=X_INIT.
    - If brake=0 and speed > 0, go to ACCEL with counter cleared.
    - Brake has priority over the return to ACCEL.
- Simultaneous events:
  - start during ACCEL, CRUISE or BRAKE is ignored.
  - brake in IDLE is ignored.
  - brake and the start latch together in IDLE: take ACCEL; brake is acted on at the next tick.
- Reset asserted mid-frame returns all outputs to reset values immediately (asynchronous). The first tick after release requires a fresh vsync rising edge.
- Outputs are all registered. Latency is 2 pclk cycles from the vsync_in edge to the updated xpos/ypos/speed/state.

Test Plan:
- Reset then 3 vsync pulses with no inputs -> state=0, speed=0, ypos=0, xpos=448; exactly 3 frame_tick pulses, each 1 cycle wide.
- Pulse start for 1 cycle mid-frame, then 40 frames -> ACCEL at the first tick; speed reaches 1 after 4 more ticks and 8 after 32; state=2 from then on. ypos is the wrapped sum of prior speeds and stays < 128.
- CRUISE at speed 8, then hold brake -> state=3; speed 7,6,…,0 on successive ticks; then state=0 and xpos=448.
- BRAKE at speed 5, release brake -> the next tick gives speed 4 and state=1; acceleration resumes from a cleared counter.
- steer_left held 500 frames from xpos=448 -> saturates at 0. steer_right held 1000 frames -> saturates at 896. Both held -> xpos unchanged.
- Assert rst mid-CRUISE with vsync held high, then release -> outputs are at reset values immediately; no frame_tick until vsync falls and rises again.
